// File: rtl/soma_pkg.sv
// Shared types and default widths for the soma timestep scheduler.
package soma_pkg;

  localparam int unsigned NnwDefault = 12;
  localparam int unsigned VwDefault  = 20;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClear,
    StDone
  } soma_state_e;

endpackage

// File: rtl/soma_idx_cnt.sv
// Neuron index counter shared by the update and zeroing sweeps.
module soma_idx_cnt #(
  parameter int unsigned NNW = 12
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           load_zero,
  input  logic           inc,
  input  logic [NNW-1:0] last_idx,
  output logic [NNW-1:0] idx,
  output logic           last
);

  logic [NNW-1:0] idx_q;

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (load_zero) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + NNW'(1);
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == last_idx);

endmodule

// File: rtl/soma_sched.sv
// Timestep scheduler: sweeps neurons 0..N-1 through a read (S0) / write+spike (S1)
// pipeline, or zeroes Vm[0..N-1] on a clear request.
module soma_sched
  import soma_pkg::*;
#(
  parameter int unsigned NNW = NnwDefault,
  parameter int unsigned VW  = VwDefault
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           cfg_enable,
  input  logic [NNW-1:0] cfg_neuron_num,
  input  logic           cfg_clear_req,
  output logic           vm_re,
  output logic [NNW-1:0] vm_raddr,
  output logic           vm_we,
  output logic [NNW-1:0] vm_waddr,
  output logic [VW-1:0]  vm_wdata,
  input  logic           soma_fire,
  input  logic [VW-1:0]  soma_vm_next,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_id,
  input  logic           spk_ready,
  output logic           busy,
  output logic           done,
  output logic [NNW:0]   spk_count,
  output logic           overrun
);

  soma_state_e    state_q;
  logic [NNW-1:0] n_q;
  logic [NNW-1:0] s1_idx_q;
  logic           s1_valid_q;
  logic           rd_active_q;
  logic [NNW:0]   spk_count_q;
  logic           overrun_q;

  logic [NNW-1:0] idx;
  logic           idx_last;
  logic           in_idle, in_run, in_clear;
  logic           advance, stall, s1_write;
  logic           tick_acc, start_run, start_clear, cnt_inc;

  assign in_idle  = (state_q == StIdle);
  assign in_run   = (state_q == StRun);
  assign in_clear = (state_q == StClear);

  // S1 holds while a firing neuron waits for the spike sink.
  assign advance  = !soma_fire || spk_ready;
  assign stall    = s1_valid_q && !advance;
  assign s1_write = in_run && s1_valid_q && advance;

  assign tick_acc    = tick && cfg_enable;
  assign start_clear = in_idle && cfg_clear_req;
  assign start_run   = in_idle && tick_acc && !cfg_clear_req;
  assign cnt_inc     = (vm_re || in_clear) && !idx_last;

  soma_idx_cnt #(
    .NNW (NNW)
  ) u_idx_cnt (
    .clk_soma  (clk_soma),
    .rst_n     (rst_n),
    .load_zero (start_run || start_clear),
    .inc       (cnt_inc),
    .last_idx  (n_q - NNW'(1)),
    .idx       (idx),
    .last      (idx_last)
  );

  assign vm_re     = in_run && rd_active_q && !stall;
  assign vm_raddr  = in_run ? idx : '0;
  assign vm_we     = s1_write || in_clear;
  assign vm_waddr  = in_clear ? idx : (in_run ? s1_idx_q : '0);
  assign vm_wdata  = s1_write ? soma_vm_next : '0;
  assign spk_valid = in_run && s1_valid_q && soma_fire;
  assign spk_id    = s1_idx_q;
  assign busy      = in_run || in_clear;
  assign done      = (state_q == StDone);
  assign spk_count = spk_count_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      s1_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      rd_active_q <= 1'b0;
      spk_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      // Any request outside IDLE is dropped; a tick losing to a clear is dropped too.
      if ((!in_idle && (tick || cfg_clear_req)) || (in_idle && cfg_clear_req && tick_acc)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (cfg_clear_req) begin
            n_q     <= cfg_neuron_num;
            state_q <= (cfg_neuron_num == '0) ? StDone : StClear;
          end else if (tick_acc) begin
            n_q         <= cfg_neuron_num;
            spk_count_q <= '0;
            s1_valid_q  <= 1'b0;
            rd_active_q <= (cfg_neuron_num != '0);
            state_q     <= (cfg_neuron_num == '0) ? StDone : StRun;
          end
        end

        StRun: begin
          if (spk_valid && spk_ready) begin
            spk_count_q <= spk_count_q + (NNW + 1)'(1);
          end
          if (!stall) begin
            s1_valid_q <= vm_re;
            s1_idx_q   <= idx;
            if (vm_re && idx_last) begin
              rd_active_q <= 1'b0;
            end
          end
          if (s1_write && !rd_active_q) begin
            state_q <= StDone;
          end
        end

        StClear: begin
          if (idx_last) begin
            state_q <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soma_sched.sv
// Self-checking bench for soma_sched with a RAM/soma stand-in and an event-timing model.
module tb_soma_sched;

  localparam int NNW = 12;
  localparam int VW  = 20;
  localparam logic [VW-1:0] VmInc = 20'h00123;

  logic           clk_soma = 1'b0;
  logic           rst_n = 1'b0;
  logic           tick = 1'b0;
  logic           cfg_enable = 1'b0;
  logic [NNW-1:0] cfg_neuron_num = '0;
  logic           cfg_clear_req = 1'b0;
  logic           vm_re;
  logic [NNW-1:0] vm_raddr;
  logic           vm_we;
  logic [NNW-1:0] vm_waddr;
  logic [VW-1:0]  vm_wdata;
  logic           soma_fire;
  logic [VW-1:0]  soma_vm_next;
  logic           spk_valid;
  logic [NNW-1:0] spk_id;
  logic           spk_ready = 1'b1;
  logic           busy;
  logic           done;
  logic [NNW:0]   spk_count;
  logic           overrun;

  int errors = 0;
  int checks = 0;

  soma_sched #(
    .NNW (NNW),
    .VW  (VW)
  ) dut (
    .clk_soma       (clk_soma),
    .rst_n          (rst_n),
    .tick           (tick),
    .cfg_enable     (cfg_enable),
    .cfg_neuron_num (cfg_neuron_num),
    .cfg_clear_req  (cfg_clear_req),
    .vm_re          (vm_re),
    .vm_raddr       (vm_raddr),
    .vm_we          (vm_we),
    .vm_waddr       (vm_waddr),
    .vm_wdata       (vm_wdata),
    .soma_fire      (soma_fire),
    .soma_vm_next   (soma_vm_next),
    .spk_valid      (spk_valid),
    .spk_id         (spk_id),
    .spk_ready      (spk_ready),
    .busy           (busy),
    .done           (done),
    .spk_count      (spk_count),
    .overrun        (overrun)
  );

  always #5 clk_soma = ~clk_soma;

  // Vm RAM / dendrite / soma stand-in: one-cycle read latency, data held between reads.
  logic [VW-1:0]  vm_mem [0:4095];
  bit             fire_mask [0:4095];
  bit             ready_pat [0:511];
  logic [NNW-1:0] lat_idx = '0;

  always @(posedge clk_soma) begin
    if (vm_re) lat_idx <= vm_raddr;
    if (vm_we) vm_mem[vm_waddr] <= vm_wdata;
  end

  assign soma_fire    = fire_mask[lat_idx];
  assign soma_vm_next = vm_mem[lat_idx] + VmInc;

  int cyc = 0;
  always @(posedge clk_soma) cyc <= cyc + 1;

  int             rd_cyc[$], rd_addr[$], wr_cyc[$], wr_addr[$], sp_cyc[$], sp_id[$];
  logic [VW-1:0]  wr_data[$];
  int             done_cyc, done_pulses, busy_cnt, stall_viol;
  logic [NNW:0]   done_cnt;
  logic           prev_stall = 1'b0;
  logic [NNW-1:0] prev_id = '0;

  always @(negedge clk_soma) begin
    if (vm_re) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(int'(vm_raddr));
    end
    if (vm_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(vm_waddr));
      wr_data.push_back(vm_wdata);
    end
    if (spk_valid && spk_ready) begin
      sp_cyc.push_back(cyc);
      sp_id.push_back(int'(spk_id));
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt = spk_count;
      done_pulses++;
    end
    if (busy) busy_cnt++;
    if (prev_stall && !(spk_valid && spk_id == prev_id)) stall_viol++;
    if (spk_valid && !spk_ready && (vm_we || vm_re)) stall_viol++;
    prev_stall = spk_valid && !spk_ready;
    prev_id    = spk_id;
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    sp_cyc.delete(); sp_id.delete();
    done_cyc = -1; done_pulses = 0; busy_cnt = 0; stall_viol = 0; done_cnt = '0;
  endtask

  task automatic step();
    @(posedge clk_soma);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 1'b0; cfg_clear_req = 1'b0; spk_ready = 1'b1;
    repeat (2) @(posedge clk_soma);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cyc < 0 && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // Sweep of n neurons; expected event times come from the stall rule applied to ready_pat.
  task automatic run_sweep(input int n, input bit perturb);
    logic [VW-1:0] old_vm[$];
    int exp_rc[$], exp_wc[$], exp_sc[$], exp_si[$];
    int t0, r, w, exp_done, exp_cnt, k;
    for (int i = 0; i < n; i++) old_vm.push_back(vm_mem[i]);
    clear_logs();
    cfg_neuron_num = NNW'(n);
    cfg_enable = 1'b1;
    tick = 1'b1;
    t0 = cyc;
    spk_ready = ready_pat[0];

    r = t0 + 1;
    exp_cnt = 0;
    for (int j = 0; j < n; j++) begin
      exp_rc.push_back(r);
      w = r + 1;
      if (fire_mask[j]) begin
        while (w - t0 < 511 && !ready_pat[w - t0]) w++;
        exp_sc.push_back(w);
        exp_si.push_back(j);
        exp_cnt++;
      end
      exp_wc.push_back(w);
      r = w;
    end
    exp_done = (n == 0) ? t0 + 1 : r + 1;

    step();
    tick = 1'b0;
    if (perturb) begin
      cfg_neuron_num = NNW'($urandom_range(0, 4095));
      cfg_enable = 1'b0;
    end
    k = 1;
    while (done_cyc < 0 && k < 500) begin
      spk_ready = ready_pat[k];
      step();
      k++;
    end
    spk_ready = 1'b1;
    repeat (3) step();
    cfg_enable = 1'b1;

    checks++;
    if (done_cyc !== exp_done) begin
      errors++;
      $display("FAIL sweep_done_cycle n=%0d: got T+%0d want T+%0d", n, done_cyc - t0, exp_done - t0);
    end
    checks++;
    if (done_pulses !== 1) begin
      errors++; $display("FAIL sweep_done_pulses: got %0d want 1", done_pulses);
    end
    checks++;
    if (done_cnt !== (NNW + 1)'(exp_cnt)) begin
      errors++; $display("FAIL spk_count_at_done: got %0d want %0d", done_cnt, exp_cnt);
    end
    checks++;
    if (spk_count !== (NNW + 1)'(exp_cnt)) begin
      errors++; $display("FAIL spk_count_hold: got %0d want %0d", spk_count, exp_cnt);
    end
    checks++;
    if (busy_cnt !== exp_done - t0 - 1) begin
      errors++; $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, exp_done - t0 - 1);
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++; $display("FAIL stall_hold: got %0d violations want 0", stall_viol);
    end
    checks++;
    if (rd_cyc.size() !== n || wr_cyc.size() !== n || sp_cyc.size() !== exp_cnt) begin
      errors++;
      $display("FAIL sweep_counts: got rd=%0d wr=%0d spk=%0d want rd=%0d wr=%0d spk=%0d",
               rd_cyc.size(), wr_cyc.size(), sp_cyc.size(), n, n, exp_cnt);
    end
    for (int j = 0; j < n && j < rd_cyc.size(); j++) begin
      checks++;
      if (rd_cyc[j] !== exp_rc[j] || rd_addr[j] !== j) begin
        errors++;
        $display("FAIL read_%0d: got T+%0d addr %0d want T+%0d addr %0d",
                 j, rd_cyc[j] - t0, rd_addr[j], exp_rc[j] - t0, j);
      end
    end
    for (int j = 0; j < n && j < wr_cyc.size(); j++) begin
      checks++;
      if (wr_cyc[j] !== exp_wc[j] || wr_addr[j] !== j || wr_data[j] !== old_vm[j] + VmInc) begin
        errors++;
        $display("FAIL write_%0d: got T+%0d addr %0d data %h want T+%0d addr %0d data %h",
                 j, wr_cyc[j] - t0, wr_addr[j], wr_data[j], exp_wc[j] - t0, j, old_vm[j] + VmInc);
      end
    end
    for (int j = 0; j < exp_cnt && j < sp_cyc.size(); j++) begin
      checks++;
      if (sp_cyc[j] !== exp_sc[j] || sp_id[j] !== exp_si[j]) begin
        errors++;
        $display("FAIL spike_%0d: got T+%0d id %0d want T+%0d id %0d",
                 j, sp_cyc[j] - t0, sp_id[j], exp_sc[j] - t0, exp_si[j]);
      end
    end
  endtask

  task automatic set_ready_all(input bit v);
    for (int k = 0; k < 512; k++) ready_pat[k] = v;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({vm_re, vm_raddr, vm_we, vm_waddr, vm_wdata, spk_valid, spk_id, busy, done, spk_count,
         overrun} !== '0) begin
      errors++;
      $display("FAIL %s: got re=%b raddr=%0d we=%b waddr=%0d wdata=%h spk=%b id=%0d busy=%b done=%b cnt=%0d ovr=%b want all 0",
               name, vm_re, vm_raddr, vm_we, vm_waddr, vm_wdata, spk_valid, spk_id, busy, done,
               spk_count, overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_outputs_zero("reset_asserted");
    do_reset();
    check_outputs_zero("reset_released");
  endtask

  task automatic test_fire_1_3();
    set_ready_all(1'b1);
    for (int i = 0; i < 4; i++) fire_mask[i] = (i == 1 || i == 3);
    run_sweep(4, 1'b0);
  endtask

  task automatic test_stall();
    set_ready_all(1'b1);
    ready_pat[2] = 1'b0;
    ready_pat[3] = 1'b0;
    for (int i = 0; i < 3; i++) fire_mask[i] = 1'b1;
    run_sweep(3, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 512; k++) ready_pat[k] = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 32; i++) fire_mask[i] = $urandom_range(0, 1) == 1;
      run_sweep($urandom_range(1, 24), it[0]);
    end
  endtask

  task automatic test_clear();
    logic [VW-1:0] keep;
    int c0;
    for (int i = 0; i < 8; i++) vm_mem[i] = VW'($urandom) | VW'(1);
    keep = vm_mem[5];
    clear_logs();
    cfg_enable = 1'b0;
    cfg_neuron_num = NNW'(5);
    cfg_clear_req = 1'b1;
    c0 = cyc;
    step();
    cfg_clear_req = 1'b0;
    wait_done(20);
    repeat (2) step();
    cfg_enable = 1'b1;
    checks++;
    if (done_cyc !== c0 + 6) begin
      errors++; $display("FAIL clear_done_cycle: got C+%0d want C+6", done_cyc - c0);
    end
    checks++;
    if (rd_cyc.size() !== 0 || wr_cyc.size() !== 5) begin
      errors++; $display("FAIL clear_counts: got rd=%0d wr=%0d want rd=0 wr=5", rd_cyc.size(), wr_cyc.size());
    end
    for (int j = 0; j < 5 && j < wr_cyc.size(); j++) begin
      checks++;
      if (wr_cyc[j] !== c0 + 1 + j || wr_addr[j] !== j || wr_data[j] !== '0) begin
        errors++;
        $display("FAIL clear_write_%0d: got C+%0d addr %0d data %h want C+%0d addr %0d data 0",
                 j, wr_cyc[j] - c0, wr_addr[j], wr_data[j], 1 + j, j);
      end
    end
    checks++;
    if (vm_mem[5] !== keep || busy_cnt !== 5 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL clear_extent: got vm5=%h busy=%0d ovr=%b want vm5=%h busy=5 ovr=0",
               vm_mem[5], busy_cnt, overrun, keep);
    end
  endtask

  task automatic test_empty();
    set_ready_all(1'b1);
    run_sweep(0, 1'b0);
    clear_logs();
    cfg_enable = 1'b0;
    cfg_neuron_num = NNW'(4);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (8) step();
    cfg_enable = 1'b1;
    checks++;
    if (rd_cyc.size() !== 0 || wr_cyc.size() !== 0 || done_pulses !== 0 || busy_cnt !== 0 ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL disabled_tick: got rd=%0d wr=%0d done=%0d busy=%0d ovr=%b want all 0",
               rd_cyc.size(), wr_cyc.size(), done_pulses, busy_cnt, overrun);
    end
  endtask

  task automatic test_overrun();
    int t0;
    do_reset();
    for (int i = 0; i < 8; i++) fire_mask[i] = 1'b0;
    clear_logs();
    cfg_enable = 1'b1;
    cfg_neuron_num = NNW'(6);
    tick = 1'b1;
    t0 = cyc;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_done(30);
    repeat (6) step();
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_tick_in_run: got %b want 1", overrun);
    end
    checks++;
    if (rd_cyc.size() !== 6 || done_pulses !== 1 || done_cyc !== t0 + 8) begin
      errors++;
      $display("FAIL overrun_no_restart: got rd=%0d done=%0d at T+%0d want rd=6 done=1 at T+8",
               rd_cyc.size(), done_pulses, done_cyc - t0);
    end

    do_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_reset: got %b want 0", overrun);
    end
    clear_logs();
    cfg_neuron_num = NNW'(3);
    tick = 1'b1;
    cfg_clear_req = 1'b1;
    t0 = cyc;
    step();
    tick = 1'b0;
    cfg_clear_req = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_tick_clear: got %b want 1", overrun);
    end
    wait_done(20);
    step();
    checks++;
    if (rd_cyc.size() !== 0 || wr_cyc.size() !== 3 || done_cyc !== t0 + 4) begin
      errors++;
      $display("FAIL tick_clear_runs_clear: got rd=%0d wr=%0d done at C+%0d want rd=0 wr=3 done at C+4",
               rd_cyc.size(), wr_cyc.size(), done_cyc - t0);
    end
    for (int j = 0; j < 3 && j < wr_data.size(); j++) begin
      checks++;
      if (wr_data[j] !== '0 || wr_addr[j] !== j) begin
        errors++;
        $display("FAIL tick_clear_write_%0d: got addr %0d data %h want addr %0d data 0",
                 j, wr_addr[j], wr_data[j], j);
      end
    end
    set_ready_all(1'b1);
    run_sweep(2, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_ready_all(1'b1);
    for (int i = 0; i < 8; i++) fire_mask[i] = $urandom_range(0, 1) == 1;
    clear_logs();
    cfg_enable = 1'b1;
    cfg_neuron_num = NNW'(8);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (2) step();
    checks++;
    if (vm_re !== 1'b1 || vm_raddr !== NNW'(2)) begin
      errors++; $display("FAIL mid_run_index: got re=%b raddr=%0d want re=1 raddr=2", vm_re, vm_raddr);
    end
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_run");
    step();
    rst_n = 1'b1;
    step();
    run_sweep(8, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vm_mem[i] = VW'($urandom);
      fire_mask[i] = 1'b0;
    end
    set_ready_all(1'b1);
    clear_logs();
    test_reset();
    test_fire_1_3();
    test_stall();
    test_random();
    test_clear();
    test_empty();
    test_overrun();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
